// File: rtl/cpu_mem_arb_pkg.sv
// cpu_mem_arb_pkg: FSM states, grant ids and default memory latency shared by the arbiter files
package cpu_mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  localparam logic GNT_IM = 1'b0;
  localparam logic GNT_DM = 1'b1;
  localparam int MEM_LAT_DEF = 1;
endpackage

// File: rtl/cpu_mem_arb_pick.sv
// cpu_mem_arb_pick: winner selection between fetch and data ports; ARB_RR_EN selects round-robin
module cpu_mem_arb_pick
  import cpu_mem_arb_pkg::*;
(
  input  logic im_req,
  input  logic dm_req,
`ifdef ARB_RR_EN
  input  logic last_grant,
`endif
  output logic vld,
  output logic gnt
);
  // On a tie, round-robin hands the port to the side that did not win last time
  always_comb begin
    vld = im_req | dm_req;
`ifdef ARB_RR_EN
    gnt = (im_req & dm_req) ? ~last_grant : (dm_req ? GNT_DM : GNT_IM);
`else
    gnt = dm_req ? GNT_DM : GNT_IM;
`endif
  end
endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one SRAM port between fetch and data ports; define ARB_RR_EN for round-robin
module cpu_mem_arbiter
  import cpu_mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                im_req,
  input  logic [ADDR_W-1:0]   im_addr,
  output logic                im_ack,
  output logic [DATA_W-1:0]   im_rdata,
  input  logic                dm_req,
  input  logic [DATA_W/8-1:0] dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_ack,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_cs,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);
  localparam int BW = DATA_W / 8;
  localparam int CW = $clog2(MEM_LAT + 1);

  state_t            state, state_nx;
  logic              pick_vld, pick_gnt, gnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BW-1:0]     we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CW-1:0]     cnt;
  logic              last_rd;

`ifdef ARB_RR_EN
  logic last_q;

  cpu_mem_arb_pick u_pick (
    .im_req    (im_req),
    .dm_req    (dm_req),
    .last_grant(last_q),
    .vld       (pick_vld),
    .gnt       (pick_gnt)
  );

  // Remember who won the most recent grant so the next tie flips sides
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= GNT_IM;
    else if (state == IDLE && pick_vld) last_q <= pick_gnt;
  end
`else
  cpu_mem_arb_pick u_pick (
    .im_req(im_req),
    .dm_req(dm_req),
    .vld   (pick_vld),
    .gnt   (pick_gnt)
  );
`endif

  assign last_rd = state == WAIT && cnt == '0;

  // State register; reset drops any in-flight transaction without an ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_nx;
  end

  // Next state: writes skip WAIT, reads wait out the memory latency
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = pick_vld ? ACCESS : IDLE;
      ACCESS:  state_nx = (we_q == '0) ? WAIT : RESP;
      WAIT:    state_nx = (cnt == '0) ? RESP : WAIT;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: memory strobe only in ACCESS, single ack to the granted port in RESP
  always_comb begin
    mem_cs    = state == ACCESS;
    mem_we    = mem_cs ? we_q : '0;
    mem_addr  = mem_cs ? addr_q : '0;
    mem_wdata = mem_cs ? wdata_q : '0;
    im_ack    = state == RESP && gnt_q == GNT_IM;
    dm_ack    = state == RESP && gnt_q == GNT_DM;
    busy      = state != IDLE;
  end

  // Latch the winner in IDLE, run the latency counter, capture read data on the last WAIT cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q    <= GNT_IM;
      addr_q   <= '0;
      we_q     <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
      im_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if (state == IDLE && pick_vld) begin
        gnt_q   <= pick_gnt;
        addr_q  <= pick_gnt == GNT_DM ? dm_addr : im_addr;
        we_q    <= pick_gnt == GNT_DM ? dm_we : '0;
        wdata_q <= pick_gnt == GNT_DM ? dm_wdata : '0;
      end
      if (state == ACCESS) cnt <= CW'(MEM_LAT - 1);
      else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (last_rd && gnt_q == GNT_DM) dm_rdata <= mem_rdata;
      if (last_rd && gnt_q == GNT_IM) im_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed vectors, corner sequences and randomized run against a transaction model
module tb_cpu_mem_arbiter;
  localparam int LAT = 1;

  typedef struct {
    logic        dm;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } vec_t;

  logic        clk, rst;
  logic        im_req, im_ack, dm_req, dm_ack, mem_cs, busy;
  logic [31:0] im_addr, im_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  dm_we, mem_we;

  logic        b_im_req, b_im_ack, b_dm_req, b_dm_ack, b_mem_cs, b_busy;
  logic [31:0] b_im_addr, b_im_rdata, b_dm_addr, b_dm_wdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_dm_we, b_mem_we;

  int          cyc, total, bad;
  logic [31:0] sram [16];
  logic [31:0] rd, junk;
  logic        rv;

  vec_t        tbl [8];
  int          n, c1, c2, acks, gnt_c, ack_c, free_c;
  logic        mact, mp, e_cs, e_ack, texp;
  logic [31:0] maddr, mwdata, mrd, im_last, dm_last, prev;
  logic [3:0]  mwe, idx;
  logic [31:0] ref_mem [16];
`ifdef ARB_RR_EN
  logic        mlast;
`endif

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .im_req(b_im_req), .im_addr(b_im_addr), .im_ack(b_im_ack), .im_rdata(b_im_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_ack(b_dm_ack), .dm_rdata(b_dm_rdata),
    .mem_cs(b_mem_cs), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  function automatic logic [31:0] init_val(input int i);
    return i == 4 ? 32'h00500093 : i == 8 ? 32'h11223344 : i == 15 ? 32'h55667788 :
           32'hA5A50000 ^ (32'(i) * 32'h00010F03);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM behind the main arbiter: read data valid one cycle after the strobe, junk otherwise
  always @(posedge clk) begin
    junk <= $urandom;
    rv <= mem_cs && mem_we == 4'h0;
    if (!rst) begin
      for (int i = 0; i < 16; i++) sram[i] <= init_val(i);
    end else if (mem_cs) begin
      rd <= sram[mem_addr[5:2]];
      for (int b = 0; b < 4; b++) if (mem_we[b]) sram[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end
  assign mem_rdata = rv ? rd : junk;
  assign b_mem_rdata = {16'hBEEF, 16'(cyc)};

  initial begin
    logic pcs, pia, pda;
    pcs = 0; pia = 0; pda = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("cs_back_to_back", 32'(mem_cs && pcs), 32'd0);
        chk("two_acks", 32'(im_ack && dm_ack), 32'd0);
        chk("im_ack_back_to_back", 32'(im_ack && pia), 32'd0);
        chk("dm_ack_back_to_back", 32'(dm_ack && pda), 32'd0);
        pcs = mem_cs; pia = im_ack; pda = dm_ack;
      end else begin
        pcs = 0; pia = 0; pda = 0;
      end
    end
  end

  task automatic do_txn(input string name, input vec_t v);
    int          k;
    logic        got;
    logic [31:0] pre;
    @(negedge clk);
    if (v.dm) begin
      dm_req = 1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      im_req = 1; im_addr = v.addr;
    end
    @(negedge clk);
    chk({name, "_cs"}, 32'(mem_cs), 32'd1);
    chk({name, "_addr"}, mem_addr, v.addr);
    chk({name, "_we"}, 32'(mem_we), 32'(v.we));
    if (v.we != 4'h0) chk({name, "_wdata"}, mem_wdata, v.wdata);
    pre = dm_rdata;
    k = 1;
    got = 0;
    while (!got && k < 12) begin
      @(negedge clk);
      k++;
      got = v.dm ? dm_ack : im_ack;
    end
    chk({name, "_ack_cycle"}, 32'(k), 32'(v.we != 4'h0 ? 2 : LAT + 2));
    chk({name, "_other_ack"}, 32'(v.dm ? im_ack : dm_ack), 32'd0);
    if (v.we != 4'h0) chk({name, "_dm_rdata_hold"}, dm_rdata, pre);
    else chk({name, "_rdata"}, v.dm ? dm_rdata : im_rdata, v.rdata);
    im_req = 0;
    dm_req = 0;
  endtask

  initial begin
    tbl[0] = '{1'b0, 4'h0, 32'h10, 32'h0,        32'h00500093};
    tbl[1] = '{1'b1, 4'h4, 32'h22, 32'h00AB0000, 32'h0};
    tbl[2] = '{1'b1, 4'h0, 32'h20, 32'h0,        32'h11AB3344};
    tbl[3] = '{1'b1, 4'hF, 32'h04, 32'hDEADBEEF, 32'h0};
    tbl[4] = '{1'b0, 4'h0, 32'h04, 32'h0,        32'hDEADBEEF};
    tbl[5] = '{1'b1, 4'h3, 32'h3C, 32'h0000CAFE, 32'h0};
    tbl[6] = '{1'b1, 4'h0, 32'h3E, 32'h0,        32'h5566CAFE};
    tbl[7] = '{1'b0, 4'h0, 32'h20, 32'h0,        32'h11AB3344};

    rst = 0;
    im_req = 0; im_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    b_im_req = 0; b_im_addr = 0; b_dm_req = 0; b_dm_we = 0; b_dm_addr = 0; b_dm_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_im_ack", 32'(im_ack), 32'd0);
    chk("rst_dm_ack", 32'(dm_ack), 32'd0);
    chk("rst_cs", 32'(mem_cs), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_im_rdata", im_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    rst = 1;

    for (int i = 0; i < 8; i++) do_txn($sformatf("vec%0d", i), tbl[i]);

    @(negedge clk);
    im_req = 1; im_addr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst = 0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cs", 32'(mem_cs), 32'd0);
    chk("midrst_im_ack", 32'(im_ack), 32'd0);
    chk("midrst_im_rdata", im_rdata, 32'd0);
    @(negedge clk);
    chk("midrst_next_im_ack", 32'(im_ack), 32'd0);
    chk("midrst_next_busy", 32'(busy), 32'd0);
    chk("midrst_next_addr", mem_addr, 32'd0);
    im_req = 0;
    rst = 1;
    do_txn("recover", tbl[0]);

    @(negedge clk);
    im_req = 1; im_addr = 32'h8; dm_req = 1; dm_addr = 32'hC; dm_we = 4'h0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!im_ack && !dm_ack && n < 20);
`ifdef ARB_RR_EN
      texp = k % 2 == 0;
`else
      texp = 1'b1;
`endif
      chk($sformatf("tie_ack%0d", k), 32'(im_ack | dm_ack), 32'd1);
      chk($sformatf("tie_winner%0d", k), 32'(dm_ack), 32'(texp));
    end
    im_req = 0;
    dm_req = 0;

    @(negedge clk);
    im_req = 1; im_addr = 32'h0;
    c1 = -1; c2 = -1; n = 0; acks = 0;
    while (acks < 2 && n < 30) begin
      @(negedge clk);
      n++;
      if (mem_cs) begin
        if (c1 < 0) c1 = cyc;
        else c2 = cyc;
      end
      if (im_ack) begin
        acks++;
        chk($sformatf("b2b_rdata%0d", acks), im_rdata, init_val(acks == 1 ? 0 : 1));
        im_addr = 32'h4;
      end
    end
    im_req = 0;
    chk("b2b_acks", 32'(acks), 32'd2);
    chk("b2b_cs_gap", 32'(c2 - c1), 32'(LAT + 3));

    @(negedge clk);
    b_dm_req = 1; b_dm_addr = 32'h40; b_dm_we = 4'h0;
    @(negedge clk);
    chk("lat3_cs", 32'(b_mem_cs), 32'd1);
    chk("lat3_addr", b_mem_addr, 32'h40);
    n = 1;
    prev = 0;
    while (!b_dm_ack && n < 12) begin
      prev = b_mem_rdata;
      @(negedge clk);
      n++;
    end
    b_dm_req = 0;
    chk("lat3_ack_cycle", 32'(n), 32'd5);
    chk("lat3_rdata", b_dm_rdata, prev);

    rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    mact = 0; free_c = 0; gnt_c = 0; ack_c = 0; mp = 0;
    maddr = 0; mwe = 0; mwdata = 0; mrd = 0; im_last = 0; dm_last = 0;
`ifdef ARB_RR_EN
    mlast = 1'b0;
`endif
    repeat (600) begin
      @(negedge clk);
      e_cs = mact && cyc == gnt_c + 1;
      e_ack = mact && cyc == ack_c;
      chk("rnd_busy", 32'(busy), 32'(mact && cyc > gnt_c));
      chk("rnd_cs", 32'(mem_cs), 32'(e_cs));
      chk("rnd_im_ack", 32'(im_ack), 32'(e_ack && !mp));
      chk("rnd_dm_ack", 32'(dm_ack), 32'(e_ack && mp));
      if (e_cs) begin
        chk("rnd_addr", mem_addr, maddr);
        chk("rnd_we", 32'(mem_we), 32'(mwe));
        if (mwe != 4'h0) chk("rnd_wdata", mem_wdata, mwdata);
      end
      if (e_ack) begin
        if (mwe != 4'h0) chk("rnd_dm_rdata_hold", dm_rdata, dm_last);
        else if (mp) begin
          chk("rnd_dm_rdata", dm_rdata, mrd);
          dm_last = mrd;
        end else begin
          chk("rnd_im_rdata", im_rdata, mrd);
          im_last = mrd;
        end
        if (mp) chk("rnd_im_rdata_hold", im_rdata, im_last);
        mact = 0;
        free_c = cyc + 1;
      end
      if (im_ack) im_req = 0;
      if (dm_ack) dm_req = 0;
      if (!im_req && $urandom_range(0, 2) == 0) begin
        im_req = 1;
        im_addr = $urandom;
      end
      if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req = 1;
        dm_addr = $urandom;
        dm_we = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
        dm_wdata = $urandom;
      end
      if (!mact && cyc >= free_c && (im_req || dm_req)) begin
`ifdef ARB_RR_EN
        mp = (im_req && dm_req) ? !mlast : dm_req;
        mlast = mp;
`else
        mp = dm_req;
`endif
        mact = 1;
        gnt_c = cyc;
        maddr = mp ? dm_addr : im_addr;
        mwe = mp ? dm_we : 4'h0;
        mwdata = dm_wdata;
        idx = maddr[5:2];
        if (mwe == 4'h0) mrd = ref_mem[idx];
        else for (int b = 0; b < 4; b++) if (mwe[b]) ref_mem[idx][8*b +: 8] = mwdata[8*b +: 8];
        ack_c = cyc + (mwe == 4'h0 ? LAT + 2 : 2);
      end
    end
    im_req = 0;
    dm_req = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
